smul: RTL and testbench
=======================

SMUL -- requirements
Module: smul

Interface
REQ-001 Parameters: none; operand format fixed at IEEE-754 binary16 (1 sign, 5 exponent bias 15, 10 fraction).
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  operand-valid strobe; A/B sampled on any rising clk edge where start=1.
REQ-005 A  input  16  binary16 multiplicand (vector element).
REQ-006 B  input  16  binary16 multiplier (scalar).
REQ-007 product  output  16  registered binary16 result of A*B.
REQ-008 V  output  1  registered overflow flag for the same result.
REQ-009 done  output  1  registered result-valid flag.

Function
REQ-010 Latency: one cycle; start=1 at edge N -> product/V/done=1 valid after edge N, held until next edge.
REQ-011 start=0 at an edge -> done=0 after that edge; product and V hold their last values.
REQ-012 start held high -> fully pipelined, one new result and done=1 every cycle; no busy state, no FSM.
REQ-013 Sign: product[15] = A[15] XOR B[15] in all cases, including zero and overflow results.
REQ-014 Significand: exponent field nonzero -> {1,frac}; exponent field zero -> {0,frac} with effective exponent 1 (subnormal support).
REQ-015 Multiply two 11-bit significands -> 22-bit raw product; unbiased exponent = eA + eB - 15 (effective exponents).
REQ-016 Normalise: shift raw product so leading 1 is in the hidden-bit position, adjusting exponent for each shift (left or right).
REQ-017 Rounding: truncation (round toward zero) of all discarded bits; no round-to-nearest, no sticky logic.
REQ-018 Normalised exponent >= 31 -> product = {sign,15'h7C00} (signed infinity), V=1.
REQ-019 Any operand with exponent field 31 (infinity or NaN pattern) -> product = {sign,15'h7C00}, V=1; this rule takes priority over zero operands.
REQ-020 Normalised exponent <= 0 -> gradual underflow: right-shift significand into subnormal form (exponent field 0), truncating; result all-zero magnitude when shifted out; V=0.
REQ-021 Either operand zero (exponent 0, fraction 0) with no exponent-31 operand -> product = {sign,15'h0000}, V=0.
REQ-022 Otherwise V=0.
REQ-023 Arithmetic datapath purely combinational from A/B to the output registers; no state between operations.

Reset
REQ-024 rst_n=0 -> immediately (asynchronous) product=16'h0000, V=0, done=0.
REQ-025 Reset asserted mid-operation discards the in-flight result; first valid result is the first start=1 edge after rst_n deasserts.
REQ-026 start ignored while rst_n=0.

Verification
REQ-027 A=16'h3C00, B=16'h3C00, start=1 -> next cycle product=16'h3C00, V=0, done=1.
REQ-028 A=16'h3C00, B=16'hBC00 -> product=16'hBC00, V=0.
REQ-029 A=16'h7CDE, B=16'h7CCC -> product=16'h7C00, V=1; also A=16'h7800, B=16'h7800 -> 16'h7C00, V=1.
REQ-030 A=16'h0201 (subnormal), B=16'h3C80 -> product=16'h0241 (truncated), V=0.
REQ-031 A=16'h0001, B=16'h0001 -> 16'h0000, V=0; A=16'h8000, B=16'h3C00 -> 16'h8000, V=0.
REQ-032 Back-to-back start for 4 cycles then start=0, rst_n pulsed low mid-stream -> done=1 each start cycle, done=0 after start drop, all outputs 0 immediately on rst_n=0.

Source files
------------

// File: rtl/smul.sv
// Purpose : binary16 (IEEE-754 half) scalar-vector multiply element, truncating, with overflow flag.
// Latency : 1 cycle; start at edge N -> product/V/done valid after edge N. Fully pipelined.
// Backpr. : none; a new operand pair is accepted on every edge with start=1, no busy state.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (clears product, V, done)
//   start    operand-valid strobe, A/B sampled on the same edge
//   A, B     binary16 operands (A = vector element, B = scalar)
//   product  registered binary16 result, holds when start=0
//   V        registered overflow flag (infinity result), holds with product
//   done     registered result-valid flag, follows start by one cycle
module smul (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] product,
    output logic        V,
    output logic        done
);

    // Operand fields
    logic        sign;
    logic [4:0]  ea_f, eb_f;
    logic [9:0]  fa, fb;
    logic        a_special, b_special;
    logic        a_zero, b_zero;

    // Significands and effective exponents (subnormals use exponent 1, hidden bit 0)
    logic [10:0] ma, mb;
    logic [4:0]  ea_eff, eb_eff;

    // Raw product, leading-one position and normalised exponent
    logic [21:0] raw;
    logic [4:0]  lead;
    logic signed [7:0] exp_n;

    // Normalised significand (hidden bit at [10]) and subnormal shift result
    logic [10:0] mnorm;
    logic [7:0]  sub_sh;
    logic [9:0]  sub_frac;

    // Next-state values for the output registers
    logic [15:0] res;
    logic        ovf;

    always_comb begin
        sign      = A[15] ^ B[15];
        ea_f      = A[14:10];
        eb_f      = B[14:10];
        fa        = A[9:0];
        fb        = B[9:0];
        a_special = &ea_f;
        b_special = &eb_f;
        a_zero    = (ea_f == 5'd0) && (fa == 10'd0);
        b_zero    = (eb_f == 5'd0) && (fb == 10'd0);

        ma     = {|ea_f, fa};
        mb     = {|eb_f, fb};
        ea_eff = (ea_f == 5'd0) ? 5'd1 : ea_f;
        eb_eff = (eb_f == 5'd0) ? 5'd1 : eb_f;
    end

    always_comb begin
        raw = {11'd0, ma} * {11'd0, mb};
    end

    // Highest set bit of the raw product; later iterations overwrite earlier ones.
    always_comb begin
        lead = 5'd0;
        for (int i = 0; i < 22; i++) begin
            if (raw[i]) begin
                lead = 5'(i);
            end
        end
    end

    // With 1.0*1.0 the leading one sits at bit 20 and the exponent is eA+eB-15;
    // every bit the leading one moves away from 20 shifts the exponent by one.
    always_comb begin
        exp_n = $signed({3'd0, ea_eff}) + $signed({3'd0, eb_eff})
              + $signed({3'd0, lead}) - 8'sd35;
    end

    // Bring the leading one to bit 10; a right shift truncates the discarded bits.
    always_comb begin
        if (lead >= 5'd10) begin
            mnorm = 11'(raw >> (lead - 5'd10));
        end else begin
            mnorm = 11'(raw << (5'd10 - lead));
        end
    end

    // Gradual underflow: an exponent of e<=0 is expressed with exponent field 0
    // by shifting the significand right by (1-e); bits shifted out are dropped.
    always_comb begin
        sub_sh   = 8'd1 - exp_n;
        sub_frac = 10'(mnorm >> sub_sh);
    end

    // Result selection. Infinity/NaN operands win over zero operands.
    always_comb begin
        res = {sign, 15'h0000};
        ovf = 1'b0;
        if (a_special || b_special) begin
            res = {sign, 15'h7C00};
            ovf = 1'b1;
        end else if (a_zero || b_zero) begin
            res = {sign, 15'h0000};
        end else if (exp_n >= 8'sd31) begin
            res = {sign, 15'h7C00};
            ovf = 1'b1;
        end else if (exp_n <= 8'sd0) begin
            res = {sign, 5'd0, sub_frac};
        end else begin
            res = {sign, exp_n[4:0], mnorm[9:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= 16'h0000;
            V       <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= start;
            if (start) begin
                product <= res;
                V       <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_smul.sv
module tb_smul;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] A = 16'h0000;
    logic [15:0] B = 16'h0000;
    logic [15:0] product;
    logic        V;
    logic        done;

    smul dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .A       (A),
        .B       (B),
        .product (product),
        .V       (V),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] p;
        logic        v;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic start_q;

    // ---------------- reference model (real arithmetic) ----------------
    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) begin
            for (int i = 0; i < k; i++) r = r * 2.0;
        end else begin
            for (int i = 0; i < -k; i++) r = r / 2.0;
        end
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        int e = int'(h[14:10]);
        int f = int'(h[9:0]);
        if (e == 0) return real'(f) * pow2(-24);
        return real'(1024 + f) * pow2(e - 25);
    endfunction

    function automatic exp_t ref_mul(input logic [15:0] a, input logic [15:0] b);
        exp_t r;
        logic s;
        real  x;
        int   e, m, f;
        logic [9:0] fr;
        logic [4:0] ef;
        s = a[15] ^ b[15];
        if (a[14:10] == 5'h1F || b[14:10] == 5'h1F) begin
            r.p = {s, 15'h7C00}; r.v = 1'b1; return r;
        end
        x = h2r(a) * h2r(b);
        if (x == 0.0) begin
            r.p = {s, 15'h0000}; r.v = 1'b0; return r;
        end
        if (x >= 65536.0) begin
            r.p = {s, 15'h7C00}; r.v = 1'b1; return r;
        end
        if (x < pow2(-14)) begin
            f  = $rtoi(x * pow2(24));
            fr = 10'(f);
            r.p = {s, 5'd0, fr}; r.v = 1'b0; return r;
        end
        e = -14;
        while (x >= pow2(e + 1)) e++;
        m  = $rtoi(x * pow2(10 - e));
        fr = 10'(m - 1024);
        ef = 5'(e + 15);
        r.p = {s, ef, fr}; r.v = 1'b0;
        return r;
    endfunction

    function automatic logic [15:0] rand_op();
        logic       s  = 1'($urandom);
        logic [9:0] fr = 10'($urandom);
        logic [4:0] ex;
        case ($urandom_range(0, 7))
            0:       return {s, 15'h0000};
            1:       return {s, 5'd0, fr};
            2:       return {s, 5'h1F, fr};
            default: begin
                ex = 5'($urandom_range(1, 30));
                return {s, ex, fr};
            end
        endcase
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check16(input string name, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) start_q <= 1'b0;
        else        start_q <= start;
    end

    logic [15:0] hold_p = 16'h0000;
    logic        hold_v = 1'b0;

    always @(negedge clk or negedge rst_n) begin
        exp_t e;
        if (!rst_n) begin
            hold_p = 16'h0000;
            hold_v = 1'b0;
            exp_q.delete();
        end else begin
            check1("done", done, start_q);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: product %h with empty scoreboard", product);
                end else begin
                    e = exp_q.pop_front();
                    check16("product", product, e.p);
                    check1("V", V, e.v);
                    hold_p = e.p;
                    hold_v = e.v;
                end
            end else begin
                check16("hold_product", product, hold_p);
                check1("hold_V", V, hold_v);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input exp_t e);
        @(posedge clk);
        #1;
        start = 1'b1;
        A     = a;
        B     = b;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = 16'($urandom);
        B     = 16'($urandom);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check16("rst_product", product, 16'h0000);
        check1("rst_V", V, 1'b0);
        check1("rst_done", done, 1'b0);
        // start must be ignored while reset is low
        start = 1'b1;
        A     = 16'h3C00;
        B     = 16'h3C00;
        @(posedge clk);
        #1;
        check1("rst_start_ignored", done, 1'b0);
        start = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
        logic        v;
    } vec_t;

    vec_t dir[$];

    initial begin
        exp_t e;
        logic [15:0] ra, rb;

        dir.push_back({16'h3C00, 16'h3C00, 16'h3C00, 1'b0});
        dir.push_back({16'h3C00, 16'hBC00, 16'hBC00, 1'b0});
        dir.push_back({16'h7CDE, 16'h7CCC, 16'h7C00, 1'b1});
        dir.push_back({16'h7800, 16'h7800, 16'h7C00, 1'b1});
        dir.push_back({16'h0201, 16'h3C80, 16'h0241, 1'b0});
        dir.push_back({16'h0001, 16'h0001, 16'h0000, 1'b0});
        dir.push_back({16'h8000, 16'h3C00, 16'h8000, 1'b0});
        dir.push_back({16'h8000, 16'h7C00, 16'hFC00, 1'b1});
        dir.push_back({16'h0000, 16'hFFFF, 16'hFC00, 1'b1});
        dir.push_back({16'h3C00, 16'h0001, 16'h0001, 1'b0});
        dir.push_back({16'h0400, 16'h3800, 16'h0200, 1'b0});
        dir.push_back({16'h7BFF, 16'h3C00, 16'h7BFF, 1'b0});

        #1;
        rst_n = 1'b0;
        #1;
        check16("init_product", product, 16'h0000);
        check1("init_V", V, 1'b0);
        check1("init_done", done, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // directed values, back to back
        foreach (dir[i]) begin
            e.p = dir[i].p;
            e.v = dir[i].v;
            issue(dir[i].a, dir[i].b, e);
        end
        idle();
        idle();

        // four back-to-back starts, drop start, then reset mid-stream
        for (int i = 0; i < 4; i++) begin
            ra = rand_op(); rb = rand_op();
            issue(ra, rb, ref_mul(ra, rb));
        end
        idle();
        idle();
        for (int i = 0; i < 3; i++) begin
            ra = rand_op(); rb = rand_op();
            issue(ra, rb, ref_mul(ra, rb));
        end
        #2;
        reset_pulse();
        idle();

        // randomized traffic with occasional gaps
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle();
            end else begin
                ra = rand_op(); rb = rand_op();
                issue(ra, rb, ref_mul(ra, rb));
            end
        end
        idle();
        repeat (3) @(posedge clk);
        #1;

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results still expected, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
